// File: rtl/store_drain.sv
// Committed-store drain: pops the store FIFO head, coalesces same-word stores
// into one staging word, and issues it as a single write on the data-memory bus.

module store_drain_lane (
  input  logic       i_load,
  input  logic       i_merge,
  input  logic       i_hbe,
  input  logic [7:0] i_hdata,
  input  logic       i_sbe,
  input  logic [7:0] i_sdata,
  output logic       o_be,
  output logic [7:0] o_data
);
  // A merge only overwrites the byte when the newer store enables it.
  assign o_data = (i_load | (i_merge & i_hbe)) ? i_hdata : i_sdata;
  assign o_be   = i_load ? i_hbe : (i_sbe | (i_merge & i_hbe));
endmodule

module store_drain #(
  parameter int AW       = 30,
  parameter int COALESCE = 1,
  parameter int MAXMERGE = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_fifo_empty,
  input  logic [AW+35:0] i_fifo_data,
  output logic          o_fifo_rd,
  output logic          o_bus_valid,
  output logic [AW-1:0] o_bus_addr,
  output logic [31:0]   o_bus_data,
  output logic [3:0]    o_bus_be,
  input  logic          i_bus_ready,
  input  logic          i_bus_ack,
  input  logic          i_bus_err,
  output logic          o_err,
  output logic [AW-1:0] o_err_addr,
  output logic          o_drained
);
  localparam int NUM_LANES = 4;
  localparam int CW        = $clog2(MAXMERGE) + 1;

  typedef enum logic [1:0] {IDLE, STAGE, REQ, WAIT} state_t;

  state_t          r_state, w_nxt;
  logic [AW-1:0]   r_waddr;
  logic [31:0]     r_data;
  logic [3:0]      r_be;
  logic [CW-1:0]   r_cnt;
  logic            r_err;
  logic [AW-1:0]   r_err_addr;

  logic [3:0]      w_hbe;
  logic [31:0]     w_hdata;
  logic [AW-1:0]   w_haddr;
  logic            w_can_merge, w_load, w_mrg, w_rd, w_fault;
  logic [NUM_LANES-1:0][7:0] w_ndata;
  logic [NUM_LANES-1:0]      w_nbe;

  assign w_hbe   = i_fifo_data[AW+35:AW+32];
  assign w_hdata = i_fifo_data[AW+31:AW];
  assign w_haddr = i_fifo_data[AW-1:0];

  assign w_can_merge = (COALESCE != 0) && !i_fifo_empty && (w_haddr == r_waddr) &&
                       (r_cnt < CW'(MAXMERGE));
  assign w_load  = (r_state == IDLE) && !i_fifo_empty;
  assign w_mrg   = (r_state == STAGE) && w_can_merge;
  assign w_fault = (r_state == WAIT) && i_bus_ack && i_bus_err;

  always_comb begin
    w_nxt = r_state;
    w_rd  = 1'b0;
    case (r_state)
      IDLE:  if (!i_fifo_empty) begin w_rd = 1'b1; w_nxt = STAGE; end
      STAGE: if (w_can_merge) w_rd = 1'b1;
             else             w_nxt = REQ;
      REQ:   if (i_bus_ready) w_nxt = WAIT;
      WAIT:  if (i_bus_ack)   w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  genvar k;
  generate
    for (k = 0; k < NUM_LANES; k++) begin : g_lane
      store_drain_lane u_lane (
        .i_load  (w_load),
        .i_merge (w_mrg),
        .i_hbe   (w_hbe[k]),
        .i_hdata (w_hdata[8*k +: 8]),
        .i_sbe   (r_be[k]),
        .i_sdata (r_data[8*k +: 8]),
        .o_be    (w_nbe[k]),
        .o_data  (w_ndata[k])
      );
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_waddr    <= '0;
      r_data     <= '0;
      r_be       <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_load || w_mrg) begin
        r_data <= w_ndata;
        r_be   <= w_nbe;
      end
      if (w_load) begin
        r_waddr <= w_haddr;
        r_cnt   <= CW'(1);
      end else if (w_mrg) begin
        r_cnt   <= r_cnt + CW'(1);
      end
      r_err <= w_fault;
      if (w_fault) r_err_addr <= r_waddr;
    end
  end

  // Pop is suppressed under reset so no entry is consumed by a state being discarded.
  assign o_fifo_rd   = w_rd && !i_reset;
  assign o_bus_valid = (r_state == REQ);
  assign o_bus_addr  = r_waddr;
  assign o_bus_data  = r_data;
  assign o_bus_be    = r_be;
  assign o_err       = r_err;
  assign o_err_addr  = r_err_addr;
  assign o_drained   = (r_state == IDLE) && i_fifo_empty;
endmodule

// File: tb/tb_store_drain.sv
// Bench for store_drain: FIFO and bus models plus a coalescing reference model
// feeding a queue of expected bus writes.

module tb_store_drain;
  localparam int AW = 30;
  localparam int MM = 4;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_fifo_empty;
  logic [AW+35:0] i_fifo_data;
  logic          o_fifo_rd;
  logic          o_bus_valid;
  logic [AW-1:0] o_bus_addr;
  logic [31:0]   o_bus_data;
  logic [3:0]    o_bus_be;
  logic          i_bus_ready;
  logic          i_bus_ack;
  logic          i_bus_err;
  logic          o_err;
  logic [AW-1:0] o_err_addr;
  logic          o_drained;

  store_drain #(.AW(AW), .COALESCE(1), .MAXMERGE(MM)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_fifo_empty(i_fifo_empty), .i_fifo_data(i_fifo_data), .o_fifo_rd(o_fifo_rd),
    .o_bus_valid(o_bus_valid), .o_bus_addr(o_bus_addr), .o_bus_data(o_bus_data),
    .o_bus_be(o_bus_be), .i_bus_ready(i_bus_ready), .i_bus_ack(i_bus_ack),
    .i_bus_err(i_bus_err), .o_err(o_err), .o_err_addr(o_err_addr), .o_drained(o_drained)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [3:0]    be;
  } wr_t;

  logic [AW+35:0] fifo_q[$];
  wr_t            exp_q[$];
  wr_t            ow, prev;
  bit             open, pend, err_next, exp_err;
  int             ocnt, ack_cnt, ack_dly, stall, pops, reqs, nchk, nerr;
  logic [AW-1:0]  exp_err_addr, last_addr;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic void upd();
    i_fifo_empty = (fifo_q.size() == 0);
    i_fifo_data  = i_fifo_empty ? '0 : fifo_q[0];
  endfunction

  // Reference coalescer: valid because each group is queued whole while the DUT is drained.
  function automatic void put(input logic [3:0] be, input logic [31:0] d, input logic [AW-1:0] a);
    fifo_q.push_back({be, d, a});
    if (open && ow.a == a && ocnt < MM) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ow.d[8*b +: 8] = d[8*b +: 8];
      ow.be = ow.be | be;
      ocnt++;
    end else begin
      if (open) exp_q.push_back(ow);
      ow.a = a; ow.d = d; ow.be = be;
      ocnt = 1;
      open = 1'b1;
    end
  endfunction

  function automatic void close();
    if (open) exp_q.push_back(ow);
    open = 1'b0;
    upd();
  endfunction

  task automatic cyc();
    bit  pop_now, acc, v, err_now;
    wr_t w;
    @(negedge i_clk);
    pop_now = o_fifo_rd;
    v       = o_bus_valid;
    acc     = o_bus_valid && i_bus_ready;
    err_now = i_bus_ack && i_bus_err;
    if (!i_reset) begin
      chk("err_pulse", 64'(o_err), 64'(exp_err));
      if (exp_err) chk("err_addr", 64'(o_err_addr), 64'(exp_err_addr));
      if (o_fifo_rd) chk("rd_when_empty", 64'(i_fifo_empty), 64'(0));
      if (o_bus_valid) begin
        chk("rd_in_req", 64'(o_fifo_rd), 64'(0));
        if (pend) begin
          chk("hold_addr", 64'(o_bus_addr), 64'(prev.a));
          chk("hold_data", 64'(o_bus_data), 64'(prev.d));
          chk("hold_be",   64'(o_bus_be),   64'(prev.be));
        end
        pend = !i_bus_ready;
        prev.a = o_bus_addr; prev.d = o_bus_data; prev.be = o_bus_be;
        if (i_bus_ready) begin
          reqs++;
          last_addr = o_bus_addr;
          if (exp_q.size() == 0) chk("unexpected_req", 64'(exp_q.size()), 64'(1));
          else begin
            w = exp_q.pop_front();
            chk("req_addr", 64'(o_bus_addr), 64'(w.a));
            chk("req_data", 64'(o_bus_data), 64'(w.d));
            chk("req_be",   64'(o_bus_be),   64'(w.be));
          end
        end
      end
    end
    @(posedge i_clk);
    #1;
    if (pop_now) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    i_bus_ack = 1'b0;
    i_bus_err = 1'b0;
    if (i_reset) begin
      ack_cnt = 0; pend = 1'b0; exp_err = 1'b0;
    end else begin
      exp_err = err_now;
      if (err_now) exp_err_addr = last_addr;
      if (acc) ack_cnt = ack_dly;
      else if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) begin
          i_bus_ack = 1'b1;
          i_bus_err = err_next;
          err_next  = 1'b0;
        end
      end
      if (v && stall > 0) stall--;
    end
    i_bus_ready = (stall == 0);
    upd();
  endtask

  task automatic drain(input int n);
    int k = 0;
    do begin
      cyc();
      k++;
    end while (!(o_drained && exp_q.size() == 0 && ack_cnt == 0 && !i_bus_ack) && k < n);
    chk("drain_left", 64'(exp_q.size()), 64'(0));
    chk("drained", 64'(o_drained), 64'(1));
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    cyc();
    i_reset = 1'b0;
    chk("rst_valid", 64'(o_bus_valid), 64'(0));
    chk("rst_rd",    64'(o_fifo_rd),   64'(0));
    chk("rst_drained", 64'(o_drained), 64'(1));
  endtask

  initial begin
    i_reset = 1'b1; i_bus_ready = 1'b1; i_bus_ack = 1'b0; i_bus_err = 1'b0;
    open = 0; pend = 0; err_next = 0; exp_err = 0; ocnt = 0; ack_cnt = 0;
    ack_dly = 1; stall = 0; pops = 0; reqs = 0; nchk = 0; nerr = 0;
    exp_err_addr = '0; last_addr = '0;
    upd();
    repeat (2) cyc();
    i_reset = 1'b0;
    chk("rst_valid", 64'(o_bus_valid), 64'(0));
    chk("rst_rd", 64'(o_fifo_rd), 64'(0));
    chk("rst_err", 64'(o_err), 64'(0));
    chk("rst_err_addr", 64'(o_err_addr), 64'(0));
    chk("rst_drained", 64'(o_drained), 64'(1));

    // T1 single store, late ack
    ack_dly = 3; pops = 0; reqs = 0;
    put(4'hF, 32'hDEADBEEF, 30'h10); close();
    drain(50);
    chk("t1_pops", 64'(pops), 64'(1));
    chk("t1_reqs", 64'(reqs), 64'(1));

    // T2 three byte stores merge into one word
    ack_dly = 1; pops = 0; reqs = 0;
    put(4'h1, 32'h0000_0011, 30'h20);
    put(4'h2, 32'h0000_2200, 30'h20);
    put(4'h4, 32'h0033_0000, 30'h20); close();
    drain(50);
    chk("t2_pops", 64'(pops), 64'(3));
    chk("t2_reqs", 64'(reqs), 64'(1));

    // T3 six same-word stores split by the merge limit
    pops = 0; reqs = 0;
    put(4'h1, 32'h0000_00A1, 30'h30);
    put(4'h2, 32'h0000_B200, 30'h30);
    put(4'h4, 32'h00C3_0000, 30'h30);
    put(4'h8, 32'hD400_0000, 30'h30);
    put(4'h3, 32'h0000_E5E5, 30'h30);
    put(4'hC, 32'hF6F6_0000, 30'h30); close();
    drain(80);
    chk("t3_pops", 64'(pops), 64'(6));
    chk("t3_reqs", 64'(reqs), 64'(2));

    // T4 bus back-pressure in REQ
    stall = 10; i_bus_ready = 1'b0; pops = 0; reqs = 0;
    put(4'h5, 32'h1234_5678, 30'h40); close();
    drain(80);
    chk("t4_stall_used", 64'(stall), 64'(0));
    chk("t4_reqs", 64'(reqs), 64'(1));

    // T5 faulted write, drain continues; adjacent words and be==0 stay separate
    ack_dly = 2; err_next = 1'b1; pops = 0; reqs = 0;
    put(4'hF, 32'hCAFE_F00D, 30'h3F);
    put(4'h3, 32'h0000_7777, 30'h41);
    put(4'h0, 32'h5555_AAAA, 30'h42); close();
    drain(100);
    chk("t5_reqs", 64'(reqs), 64'(3));
    chk("t5_err_addr", 64'(o_err_addr), 64'(30'h3F));

    // T6a reset while waiting for ack
    ack_dly = 20; reqs = 0;
    put(4'hF, 32'h0BAD_0BAD, 30'h50); close();
    for (int i = 0; i < 20 && ack_cnt == 0; i++) cyc();
    chk("t6a_in_wait", 64'(reqs), 64'(1));
    do_reset();
    ack_dly = 1;
    put(4'h1, 32'h0000_0099, 30'h51); close();
    drain(50);

    // T6b reset while staging: the staged entry is abandoned
    put(4'hF, 32'h6666_6666, 30'h60); close();
    cyc();
    do_reset();
    exp_q.delete();
    put(4'h8, 32'h7700_0000, 30'h61); close();
    drain(50);
    chk("t6_err_kept", 64'(o_err_addr), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
